// File: rtl/mmss_updown_timer.sv
// mm:ss up/down timer with built-in clk -> us -> ms -> s prescaler,
// BCD digit outputs, load/start/stop control and terminal-count pulses.
module mmss_updown_timer #(
    parameter int CLKS_PER_USEC = 125,
    parameter int USEC_PER_MSEC = 1000,
    parameter int MSEC_PER_SEC  = 1000,
    parameter int MIN_MOD       = 60
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       start_stop,
    input  logic       mode_down,
    input  logic       load_en,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec10,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min10,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       running,
    output logic       tick_sec,
    output logic       wrap,
    output logic       done
);

    localparam int CW = (CLKS_PER_USEC > 1) ? $clog2(CLKS_PER_USEC) : 1;
    localparam int UW = (USEC_PER_MSEC > 1) ? $clog2(USEC_PER_MSEC) : 1;
    localparam int MW = (MSEC_PER_SEC  > 1) ? $clog2(MSEC_PER_SEC)  : 1;

    localparam logic [CW-1:0] CLK_MAX = CW'(CLKS_PER_USEC - 1);
    localparam logic [UW-1:0] US_MAX  = UW'(USEC_PER_MSEC - 1);
    localparam logic [MW-1:0] MS_MAX  = MW'(MSEC_PER_SEC - 1);
    localparam logic [7:0]    MIN_MAX = 8'(MIN_MOD - 1);
    localparam logic [3:0]    MAX_M10 = 4'((MIN_MOD - 1) / 10);
    localparam logic [3:0]    MAX_M1  = 4'((MIN_MOD - 1) % 10);

    logic [CW-1:0] c_clk_q, c_clk_d;
    logic [UW-1:0] c_us_q, c_us_d;
    logic [MW-1:0] c_ms_q, c_ms_d;
    logic [3:0]    sec1_q, sec1_d, sec10_q, sec10_d, min1_q, min1_d, min10_q, min10_d;
    logic          running_q, running_d, tick_q, tick_d, wrap_q, wrap_d, done_q, done_d;

    logic          step;
    logic [7:0]    min_val;
    logic          cur_zero, nxt_zero;
    logic [3:0]    up_s1, up_s10, up_m1, up_m10;
    logic          up_wrap;
    logic [3:0]    dn_s1, dn_s10, dn_m1, dn_m10;
    logic          dn_zero;
    logic [3:0]    ld_s1, ld_s10, ld_m1, ld_m10;
    logic [7:0]    ld_min_val;

    assign step     = running_q && (c_clk_q == CLK_MAX) && (c_us_q == US_MAX) && (c_ms_q == MS_MAX);
    assign min_val  = {4'd0, min10_q} * 8'd10 + {4'd0, min1_q};
    assign cur_zero = ({min10_q, min1_q, sec10_q, sec1_q} == 16'h0000);
    assign dn_zero  = ({dn_m10, dn_m1, dn_s10, dn_s1} == 16'h0000);
    assign nxt_zero = ({min10_d, min1_d, sec10_d, sec1_d} == 16'h0000);

    // BCD increment with minute modulus; wrap flags the (MIN_MOD-1):59 -> 00:00 step
    always_comb begin
        up_s1   = sec1_q + 4'd1;
        up_s10  = sec10_q;
        up_m1   = min1_q;
        up_m10  = min10_q;
        up_wrap = 1'b0;
        if (sec1_q >= 4'd9) begin
            up_s1 = 4'd0;
            if (sec10_q >= 4'd5) begin
                up_s10 = 4'd0;
                if (min_val >= MIN_MAX) begin
                    up_m1   = 4'd0;
                    up_m10  = 4'd0;
                    up_wrap = 1'b1;
                end else if (min1_q >= 4'd9) begin
                    up_m1  = 4'd0;
                    up_m10 = min10_q + 4'd1;
                end else begin
                    up_m1 = min1_q + 4'd1;
                end
            end else begin
                up_s10 = sec10_q + 4'd1;
            end
        end
    end

    // BCD decrement; the minute underflow branch only matters for 00:00, which the
    // main logic intercepts before it is used
    always_comb begin
        dn_s1  = sec1_q - 4'd1;
        dn_s10 = sec10_q;
        dn_m1  = min1_q;
        dn_m10 = min10_q;
        if (sec1_q == 4'd0) begin
            dn_s1 = 4'd9;
            if (sec10_q == 4'd0) begin
                dn_s10 = 4'd5;
                if (min_val == 8'd0) begin
                    dn_m1  = MAX_M1;
                    dn_m10 = MAX_M10;
                end else if (min1_q == 4'd0) begin
                    dn_m1  = 4'd9;
                    dn_m10 = min10_q - 4'd1;
                end else begin
                    dn_m1 = min1_q - 4'd1;
                end
            end else begin
                dn_s10 = sec10_q - 4'd1;
            end
        end
    end

    // Load value clamping: per-digit first, then the minute value against the modulus
    always_comb begin
        ld_s1  = (set_sec1  > 4'd9) ? 4'd9 : set_sec1;
        ld_s10 = (set_sec10 > 4'd5) ? 4'd5 : set_sec10;
        ld_m1  = (set_min1  > 4'd9) ? 4'd9 : set_min1;
        ld_m10 = (set_min10 > 4'd9) ? 4'd9 : set_min10;
        ld_min_val = {4'd0, ld_m10} * 8'd10 + {4'd0, ld_m1};
        if (ld_min_val > MIN_MAX) begin
            ld_m1  = MAX_M1;
            ld_m10 = MAX_M10;
        end
    end

    // Next-state: load > start_stop > step; start_stop is applied on top of the step result
    always_comb begin
        c_clk_d   = c_clk_q;
        c_us_d    = c_us_q;
        c_ms_d    = c_ms_q;
        sec1_d    = sec1_q;
        sec10_d   = sec10_q;
        min1_d    = min1_q;
        min10_d   = min10_q;
        running_d = running_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        done_d    = 1'b0;
        if (load_en) begin
            c_clk_d   = '0;
            c_us_d    = '0;
            c_ms_d    = '0;
            sec1_d    = ld_s1;
            sec10_d   = ld_s10;
            min1_d    = ld_m1;
            min10_d   = ld_m10;
            running_d = 1'b0;
        end else begin
            if (running_q) begin
                if (c_clk_q == CLK_MAX) begin
                    c_clk_d = '0;
                    if (c_us_q == US_MAX) begin
                        c_us_d = '0;
                        c_ms_d = (c_ms_q == MS_MAX) ? '0 : c_ms_q + MW'(1);
                    end else begin
                        c_us_d = c_us_q + UW'(1);
                    end
                end else begin
                    c_clk_d = c_clk_q + CW'(1);
                end
            end
            if (step) begin
                tick_d = 1'b1;
                if (mode_down) begin
                    if (cur_zero) begin
                        done_d    = 1'b1;
                        running_d = 1'b0;
                    end else begin
                        sec1_d  = dn_s1;
                        sec10_d = dn_s10;
                        min1_d  = dn_m1;
                        min10_d = dn_m10;
                        if (dn_zero) begin
                            done_d    = 1'b1;
                            running_d = 1'b0;
                        end
                    end
                end else begin
                    sec1_d  = up_s1;
                    sec10_d = up_s10;
                    min1_d  = up_m1;
                    min10_d = up_m10;
                    wrap_d  = up_wrap;
                end
            end
            if (start_stop && !(!running_d && mode_down && nxt_zero)) begin
                running_d = !running_d;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            c_clk_q   <= '0;
            c_us_q    <= '0;
            c_ms_q    <= '0;
            sec1_q    <= 4'd0;
            sec10_q   <= 4'd0;
            min1_q    <= 4'd0;
            min10_q   <= 4'd0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            c_clk_q   <= c_clk_d;
            c_us_q    <= c_us_d;
            c_ms_q    <= c_ms_d;
            sec1_q    <= sec1_d;
            sec10_q   <= sec10_d;
            min1_q    <= min1_d;
            min10_q   <= min10_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign sec1     = sec1_q;
    assign sec10    = sec10_q;
    assign min1     = min1_q;
    assign min10    = min10_q;
    assign running  = running_q;
    assign tick_sec = tick_q;
    assign wrap     = wrap_q;
    assign done     = done_q;

endmodule
